// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_pkg
// Brief    : Shared states, marker codes and error codes for the JPEG parser.
// Revision : 1.0
// ============================================================================
package jpeg_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_SOI, S_MARK, S_LEN_H, S_LEN_L, S_SEG, S_ECS, S_ECS_FF, S_ERR
  } state_t;

  localparam logic [7:0] c_FILL  = 8'hFF;
  localparam logic [7:0] c_STUFF = 8'h00;
  localparam logic [7:0] c_SOI   = 8'hD8;
  localparam logic [7:0] c_EOI   = 8'hD9;
  localparam logic [7:0] c_SOF0  = 8'hC0;
  localparam logic [7:0] c_DHT   = 8'hC4;
  localparam logic [7:0] c_SOS   = 8'hDA;
  localparam logic [7:0] c_DQT   = 8'hDB;
  localparam logic [7:0] c_RST0  = 8'hD0;
  localparam logic [7:0] c_RST7  = 8'hD7;
  localparam logic [7:0] c_APP0  = 8'hE0;
  localparam logic [7:0] c_APP15 = 8'hEF;
  localparam logic [7:0] c_COM   = 8'hFE;

  localparam logic [2:0] c_ERR_NONE  = 3'd0;
  localparam logic [2:0] c_ERR_SOI   = 3'd1;
  localparam logic [2:0] c_ERR_TRUNC = 3'd2;
  localparam logic [2:0] c_ERR_MARK  = 3'd3;
  localparam logic [2:0] c_ERR_DIM   = 3'd4;
  localparam logic [2:0] c_ERR_LEN   = 3'd5;

  // Markers that carry a length-prefixed segment body.
  function automatic logic is_seg_marker(input logic [7:0] code);
    return (code == c_SOF0) || (code == c_DHT) || (code == c_SOS) ||
           (code == c_DQT) || (code == c_COM) ||
           ((code >= c_APP0) && (code <= c_APP15));
  endfunction

  function automatic logic is_rst_marker(input logic [7:0] code);
    return (code >= c_RST0) && (code <= c_RST7);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_ecs_destuff.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_ecs_destuff
// Brief    : ECS byte de-stuffing, RST drop and one-byte hold until EOI.
// Revision : 1.0
// ============================================================================
module jpeg_ecs_destuff
  import jpeg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic       i_ff_phase,
  input  logic       i_abort,
  input  logic       i_vaild,
  input  logic [7:0] i_byte,
  output logic       o_vaild,
  output logic       o_last,
  output logic [7:0] o_data,
  output logic       o_eoi_seen
);

  logic [7:0] r_held;
  logic       r_held_v;
  logic       w_take;
  logic       w_data_byte;
  logic       w_eoi;

  assign w_take      = i_en & i_vaild & ~i_abort;
  assign w_data_byte = w_take & (i_ff_phase ? (i_byte == c_STUFF) : (i_byte != c_FILL));
  assign w_eoi       = w_take & i_ff_phase & (i_byte == c_EOI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held     <= 8'h00;
      r_held_v   <= 1'b0;
      o_vaild    <= 1'b0;
      o_last     <= 1'b0;
      o_data     <= 8'h00;
      o_eoi_seen <= 1'b0;
    end else if (i_clear) begin
      r_held     <= 8'h00;
      r_held_v   <= 1'b0;
      o_vaild    <= 1'b0;
      o_last     <= 1'b0;
      o_data     <= 8'h00;
      o_eoi_seen <= 1'b0;
    end else begin
      o_vaild    <= 1'b0;
      o_last     <= 1'b0;
      o_eoi_seen <= 1'b0;
      if (i_abort) begin
        r_held_v <= 1'b0;
      end
      // A byte is only released once a successor proves it is not the final one.
      if (w_data_byte) begin
        if (r_held_v) begin
          o_vaild <= 1'b1;
          o_data  <= r_held;
        end
        r_held   <= i_ff_phase ? c_FILL : i_byte;
        r_held_v <= 1'b1;
      end else if (w_eoi) begin
        if (r_held_v) begin
          o_vaild <= 1'b1;
          o_last  <= 1'b1;
          o_data  <= r_held;
        end
        r_held_v   <= 1'b0;
        o_eoi_seen <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/jpeg_stream_parser.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_stream_parser
// Brief    : Validates JPEG marker structure, captures SOF0 size, emits ECS.
// Revision : 1.0
// ============================================================================
module jpeg_stream_parser
  import jpeg_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 720,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        jpeg_data_vaild,
  input  logic        jpeg_data_last,
  input  logic [7:0]  jpeg_data,
  output logic        ecs_data_vaild,
  output logic        ecs_data_last,
  output logic [7:0]  ecs_data,
  output logic [15:0] img_width,
  output logic [15:0] img_height,
  output logic        frame_done,
  output logic        frame_err,
  output logic [2:0]  err_code
);

  state_t      r_state;
  state_t      w_state_n;
  logic        r_mark_ff;
  logic [7:0]  r_marker;
  logic [7:0]  r_len_h;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [15:0] r_sof_h;
  logic [15:0] r_sof_w;
  logic [15:0] w_sof_h;
  logic [15:0] w_sof_w;
  logic [15:0] w_len;
  logic [2:0]  w_err;
  logic        w_accept;
  logic        w_trunc;
  logic        w_abort;
  logic        w_ecs_en;

  assign w_accept = jpeg_data_vaild & ~start;
  assign w_len    = {r_len_h, jpeg_data};
  assign w_trunc  = w_accept & jpeg_data_last & (r_state != S_ERR) &
                    ~((r_state == S_ECS_FF) && (jpeg_data == c_EOI));
  assign w_abort  = w_trunc | (w_accept & (w_state_n == S_ERR) & (r_state != S_ERR));
  assign w_ecs_en = (r_state == S_ECS) || (r_state == S_ECS_FF);

  // SOF0 body: byte 0 precision, 1-2 height, 3-4 width.
  always_comb begin
    w_sof_h = r_sof_h;
    w_sof_w = r_sof_w;
    case (r_idx)
      3'd1:    w_sof_h[15:8] = jpeg_data;
      3'd2:    w_sof_h[7:0]  = jpeg_data;
      3'd3:    w_sof_w[15:8] = jpeg_data;
      3'd4:    w_sof_w[7:0]  = jpeg_data;
      default: ;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_err     = c_ERR_NONE;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (jpeg_data == c_FILL) w_state_n = S_SOI;
          else begin w_err = c_ERR_SOI; w_state_n = S_ERR; end
        end
        S_SOI: begin
          if (jpeg_data == c_SOI) w_state_n = S_MARK;
          else begin w_err = c_ERR_SOI; w_state_n = S_ERR; end
        end
        S_MARK: begin
          if (!r_mark_ff) begin
            if (jpeg_data != c_FILL) begin w_err = c_ERR_MARK; w_state_n = S_ERR; end
          end else if (jpeg_data == c_FILL) begin
            w_state_n = S_MARK;
          end else if (is_seg_marker(jpeg_data)) begin
            w_state_n = S_LEN_H;
          end else begin
            w_err = c_ERR_MARK; w_state_n = S_ERR;
          end
        end
        S_LEN_H: w_state_n = S_LEN_L;
        S_LEN_L: begin
          if (w_len < 16'd2) begin w_err = c_ERR_LEN; w_state_n = S_ERR; end
          else if (w_len == 16'd2) w_state_n = (r_marker == c_SOS) ? S_ECS : S_MARK;
          else w_state_n = S_SEG;
        end
        S_SEG: begin
          if (r_cnt == 16'd1) begin
            w_state_n = (r_marker == c_SOS) ? S_ECS : S_MARK;
            if ((r_marker == c_SOF0) &&
                ((w_sof_h != 16'(V_ACTIVE)) || (w_sof_w != 16'(H_ACTIVE))))
              w_err = c_ERR_DIM;
          end
        end
        S_ECS: if (jpeg_data == c_FILL) w_state_n = S_ECS_FF;
        S_ECS_FF: begin
          if ((jpeg_data == c_STUFF) || is_rst_marker(jpeg_data)) w_state_n = S_ECS;
          else if (jpeg_data == c_FILL) w_state_n = S_ECS_FF;
          else if (jpeg_data == c_EOI) w_state_n = S_IDLE;
          else begin w_err = c_ERR_MARK; w_state_n = S_ERR; end
        end
        S_ERR:   if (jpeg_data_last) w_state_n = S_IDLE;
        default: w_state_n = S_IDLE;
      endcase
      // A premature last ends the frame; an earlier cause in the same byte keeps priority.
      if (w_trunc) begin
        w_state_n = S_IDLE;
        if (w_err == c_ERR_NONE) w_err = c_ERR_TRUNC;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE; r_mark_ff <= 1'b0; r_marker <= 8'h00; r_len_h <= 8'h00;
      r_cnt <= 16'h0; r_idx <= 3'd0; r_sof_h <= 16'h0; r_sof_w <= 16'h0;
      img_width <= 16'h0; img_height <= 16'h0; frame_err <= 1'b0; err_code <= c_ERR_NONE;
    end else if (start) begin
      r_state <= S_IDLE; r_mark_ff <= 1'b0; r_marker <= 8'h00; r_len_h <= 8'h00;
      r_cnt <= 16'h0; r_idx <= 3'd0; r_sof_h <= 16'h0; r_sof_w <= 16'h0;
      img_width <= 16'h0; img_height <= 16'h0; frame_err <= 1'b0; err_code <= c_ERR_NONE;
    end else begin
      r_state <= w_state_n;
      if ((w_err != c_ERR_NONE) && !frame_err) begin
        frame_err <= 1'b1;
        err_code  <= w_err;
      end
      if (w_accept) begin
        r_mark_ff <= (r_state == S_MARK) && (jpeg_data == c_FILL);
        case (r_state)
          S_MARK: begin
            if (r_mark_ff && is_seg_marker(jpeg_data)) begin
              r_marker <= jpeg_data;
              r_sof_h  <= 16'h0;
              r_sof_w  <= 16'h0;
            end
          end
          S_LEN_H: r_len_h <= jpeg_data;
          S_LEN_L: begin
            r_cnt <= w_len - 16'd2;
            r_idx <= 3'd0;
          end
          S_SEG: begin
            r_cnt <= r_cnt - 16'd1;
            if (r_idx != 3'd5) r_idx <= r_idx + 3'd1;
            if (r_marker == c_SOF0) begin
              r_sof_h <= w_sof_h;
              r_sof_w <= w_sof_w;
              if (r_cnt == 16'd1) begin
                img_height <= w_sof_h;
                img_width  <= w_sof_w;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  jpeg_ecs_destuff u_destuff (
    .clk        (sys_clk),
    .rst_n      (rst_n),
    .i_clear    (start),
    .i_en       (w_ecs_en),
    .i_ff_phase (r_state == S_ECS_FF),
    .i_abort    (w_abort),
    .i_vaild    (w_accept),
    .i_byte     (jpeg_data),
    .o_vaild    (ecs_data_vaild),
    .o_last     (ecs_data_last),
    .o_data     (ecs_data),
    .o_eoi_seen (frame_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_jpeg_stream_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_stream_parser
// Brief    : Scoreboard bench for jpeg_stream_parser with directed frames.
// Revision : 1.0
// ============================================================================
module tb_jpeg_stream_parser;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        jpeg_data_vaild = 1'b0;
  logic        jpeg_data_last = 1'b0;
  logic [7:0]  jpeg_data = 8'h00;
  logic        ecs_data_vaild;
  logic        ecs_data_last;
  logic [7:0]  ecs_data;
  logic [15:0] img_width;
  logic [15:0] img_height;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  err_code;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [8:0] exp_q[$];
  logic [7:0] tx[$];

  always #5 sys_clk = ~sys_clk;

  jpeg_stream_parser #(.H_ACTIVE(720), .V_ACTIVE(480)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start),
    .jpeg_data_vaild(jpeg_data_vaild), .jpeg_data_last(jpeg_data_last), .jpeg_data(jpeg_data),
    .ecs_data_vaild(ecs_data_vaild), .ecs_data_last(ecs_data_last), .ecs_data(ecs_data),
    .img_width(img_width), .img_height(img_height), .frame_done(frame_done),
    .frame_err(frame_err), .err_code(err_code)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SOI, SOF0 (height 480, width w, 3 components) and SOS header.
  task automatic add_hdr(input logic [15:0] w);
    logic [7:0] h [0:34];
    h = '{8'hFF, 8'hD8, 8'hFF, 8'hC0, 8'h00, 8'h11, 8'h08, 8'h01, 8'hE0, w[15:8], w[7:0],
          8'h03, 8'h01, 8'h22, 8'h00, 8'h02, 8'h11, 8'h01, 8'h03, 8'h11, 8'h01,
          8'hFF, 8'hDA, 8'h00, 8'h0C, 8'h03, 8'h01, 8'h00, 8'h02, 8'h11, 8'h03,
          8'h11, 8'h00, 8'h3F, 8'h00};
    for (int i = 0; i < 35; i++) tx.push_back(h[i]);
  endtask

  task automatic send_tx(input bit with_last);
    for (int i = 0; i < tx.size(); i++) begin
      @(posedge sys_clk); #1;
      jpeg_data_vaild = 1'b1;
      jpeg_data       = tx[i];
      jpeg_data_last  = with_last && (i == tx.size() - 1);
    end
    @(posedge sys_clk); #1;
    jpeg_data_vaild = 1'b0;
    jpeg_data_last  = 1'b0;
    tx.delete();
    repeat (3) @(posedge sys_clk);
  endtask

  task automatic pulse_start(input bit with_byte);
    @(posedge sys_clk); #1;
    start = 1'b1;
    jpeg_data_vaild = with_byte;
    jpeg_data = 8'h00;
    @(posedge sys_clk); #1;
    start = 1'b0;
    jpeg_data_vaild = 1'b0;
    repeat (2) @(posedge sys_clk);
  endtask

  initial begin
    fork
      forever begin
        @(negedge sys_clk);
        if (rst_n && ecs_data_vaild) begin
          if (exp_q.size() == 0) begin
            check("ecs_unexpected", {23'd0, ecs_data_last, ecs_data}, 32'h1FF);
          end else begin
            check("ecs_byte", {23'd0, ecs_data_last, ecs_data}, {23'd0, exp_q.pop_front()});
          end
        end
        if (rst_n && frame_done) done_cnt++;
      end
    join_none

    // Reset state
    #12;
    check("rst_vaild", {31'd0, ecs_data_vaild}, 0);
    check("rst_data", {24'd0, ecs_data}, 0);
    check("rst_width", {16'd0, img_width}, 0);
    check("rst_err", {28'd0, frame_err, err_code}, 0);
    @(negedge sys_clk); rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);

    // Minimal frame
    add_hdr(16'h02D0);
    tx.push_back(8'h12); tx.push_back(8'h34); tx.push_back(8'hFF); tx.push_back(8'hD9);
    exp_q.push_back(9'h012); exp_q.push_back(9'h134); exp_done++;
    send_tx(1);
    check("min_done", done_cnt, exp_done);
    check("min_width", {16'd0, img_width}, 720);
    check("min_height", {16'd0, img_height}, 480);
    check("min_err", {28'd0, frame_err, err_code}, 0);

    // Stuffed FF and RST marker
    add_hdr(16'h02D0);
    tx.push_back(8'h12); tx.push_back(8'hFF); tx.push_back(8'h00); tx.push_back(8'hFF);
    tx.push_back(8'hD3); tx.push_back(8'h56); tx.push_back(8'hFF); tx.push_back(8'hD9);
    exp_q.push_back(9'h012); exp_q.push_back(9'h0FF); exp_q.push_back(9'h156); exp_done++;
    send_tx(1);
    check("stuff_done", done_cnt, exp_done);
    check("stuff_err", {28'd0, frame_err, err_code}, 0);

    // Bad SOI, then a clean frame with the error still sticky
    tx.push_back(8'h00); tx.push_back(8'hD8); tx.push_back(8'h12);
    tx.push_back(8'h34); tx.push_back(8'hFF); tx.push_back(8'hD9);
    send_tx(1);
    check("soi_err", {28'd0, frame_err, err_code}, {28'd0, 1'b1, 3'd1});
    check("soi_done", done_cnt, exp_done);
    add_hdr(16'h02D0);
    tx.push_back(8'hAB); tx.push_back(8'hFF); tx.push_back(8'hD9);
    exp_q.push_back(9'h1AB); exp_done++;
    send_tx(1);
    check("soi_recover_done", done_cnt, exp_done);
    check("soi_sticky", {29'd0, err_code}, 1);
    pulse_start(0);
    check("start_clear", {28'd0, frame_err, err_code}, 0);

    // Segment length below 2
    tx.push_back(8'hFF); tx.push_back(8'hD8); tx.push_back(8'hFF); tx.push_back(8'hDB);
    tx.push_back(8'h00); tx.push_back(8'h01); tx.push_back(8'h00);
    send_tx(1);
    check("len_err", {29'd0, err_code}, 5);
    pulse_start(0);

    // Truncated frame: last on an ECS byte, held byte discarded
    add_hdr(16'h02D0);
    tx.push_back(8'h12); tx.push_back(8'h34); tx.push_back(8'h56);
    exp_q.push_back(9'h012);
    send_tx(1);
    check("trunc_err", {29'd0, err_code}, 2);
    check("trunc_done", done_cnt, exp_done);

    // start wins over a same-cycle byte (00 would be a bad SOI)
    pulse_start(1);
    check("start_drop", {28'd0, frame_err, err_code}, 0);

    // Width mismatch is non-fatal
    add_hdr(16'h0280);
    tx.push_back(8'h77); tx.push_back(8'h88); tx.push_back(8'hFF); tx.push_back(8'hD9);
    exp_q.push_back(9'h077); exp_q.push_back(9'h188); exp_done++;
    send_tx(1);
    check("dim_err", {28'd0, frame_err, err_code}, {28'd0, 1'b1, 3'd4});
    check("dim_width", {16'd0, img_width}, 32'h0280);
    check("dim_done", done_cnt, exp_done);
    pulse_start(0);

    // Reset mid-ECS with a held byte pending
    add_hdr(16'h02D0);
    tx.push_back(8'h12); tx.push_back(8'h34);
    exp_q.push_back(9'h012);
    send_tx(0);
    @(negedge sys_clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_width", {16'd0, img_width}, 0);
    check("arst_vaild", {31'd0, ecs_data_vaild}, 0);
    check("arst_err", {28'd0, frame_err, err_code}, 0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    add_hdr(16'h02D0);
    tx.push_back(8'h99); tx.push_back(8'hFF); tx.push_back(8'hD9);
    exp_q.push_back(9'h199); exp_done++;
    send_tx(1);
    check("arst_done", done_cnt, exp_done);
    check("arst_height", {16'd0, img_height}, 480);

    repeat (5) @(posedge sys_clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jpeg_stream_parser.md
Name: jpeg_stream_parser

Overview:
- Receive-side counterpart of the JPEG encoder: consumes the encoder's byte stream (valid/last/byte, no backpressure) and validates the marker structure SOI … EOI.
- Captures image dimensions from SOF0.
- Strips header segments and emits the de-stuffed entropy-coded segment (ECS) for a downstream Huffman decoder.
- Also serves as a self-check monitor on the encoder output in loopback benches.

Parameters:
- H_ACTIVE, 720, expected image width; checked against SOF0.
- V_ACTIVE, 480, expected image height; checked against SOF0.

Ports:
- sys_clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse: clear status, abort any frame, go to S_IDLE.
- jpeg_data_vaild  input  1  input byte qualifier.
- jpeg_data_last  input  1  marks last byte of frame; only meaningful with vaild.
- jpeg_data  input  8  input byte.
- ecs_data_vaild  output  1  de-stuffed ECS byte valid.
- ecs_data_last  output  1  final ECS byte of frame.
- ecs_data  output  8  de-stuffed ECS byte.
- img_width  output  16  width from SOF0.
- img_height  output  16  height from SOF0.
- frame_done  output  1  one-cycle pulse, EOI parsed.
- frame_err  output  1  sticky error flag.
- err_code  output  3  first error cause; 0 = none.

Behaviour:
- Reset (async assert, sync release) and start: all outputs 0, FSM in S_IDLE, held-byte register empty.
- Input accepted on every cycle with jpeg_data_vaild=1. There is no stall, so the block must take one byte per cycle indefinitely.
- FSM states: S_IDLE, S_SOI, S_MARK, S_LEN_H, S_LEN_L, S_SEG, S_ECS, S_ECS_FF, S_ERR.
- S_IDLE:
  - byte FF -> S_SOI.
  - any other byte -> err 1, S_ERR.
- S_SOI:
  - D8 -> S_MARK.
  - else -> err 1.
- S_MARK: expect FF then marker code.
  - Extra FF fill bytes are ignored.
  - Codes C0 (SOF0), C4, DA, DB, E0–EF, FE -> S_LEN_H; marker code is latched.
  - D9 here (no SOS) -> err 3.
  - Any other code -> err 3.
- S_LEN_H, S_LEN_L: 16-bit big-endian segment length L.
  - L<2 -> err 5.
  - Else body count = L-2.
  - If count is 0: next state is S_ECS when marker was DA, else S_MARK.
- S_SEG: consume count bytes.
  - For SOF0, body bytes 1–2 -> img_height and bytes 3–4 -> img_width, big-endian. They are updated when the segment completes.
  - Mismatch vs V_ACTIVE/H_ACTIVE -> err 4, but parsing continues (non-fatal).
  - At count exhaustion: DA -> S_ECS, else S_MARK.
- S_ECS: one-byte holding register `held`, required because a byte cannot be known to be final until FF D9 is seen.
  - Non-FF byte b: if held is full, emit held (vaild=1, last=0) next cycle; then held<=b.
  - FF -> S_ECS_FF, nothing emitted.
- S_ECS_FF:
  - 00 -> data byte FF, treated as above; -> S_ECS.
  - D0–D7 (RST) -> discarded; -> S_ECS.
  - FF -> stay (fill).
  - D9 -> emit held with ecs_data_last=1 (if held empty, no ECS output) and pulse frame_done, both in the cycle after D9 acceptance; -> S_IDLE.
  - Other codes -> err 3.
- Output latency: every ECS byte appears exactly one cycle after the acceptance of the next ECS data byte or of the EOI D9. At most one output per cycle.
- jpeg_data_last accepted in any state other than the D9 of EOI -> err 2, then S_IDLE. Same cycle as the D9 is normal.
- S_ERR: drop bytes until jpeg_data_last, then -> S_IDLE. No ECS output and no frame_done in S_ERR.
- frame_err/err_code:
  - Set on the first error, held until reset or start.
  - A later error never overwrites err_code.
  - err 4 sets frame_err without leaving the normal flow.
- start in the same cycle as input valid: start wins and the byte is dropped.
- Length counter is 16 bits; no wrap handling needed beyond L≤FFFF.

Decomposition:
- Package jpeg_pkg holds:
  - state enum;
  - marker constants: SOI D8, EOI D9, SOF0 C0, DHT C4, SOS DA, DQT DB, RST range D0–D7;
  - err_code constants: 1 bad SOI, 2 truncated, 3 bad marker, 4 dim mismatch, 5 bad length.
- One natural sub-module: jpeg_ecs_destuff, containing the S_ECS/S_ECS_FF byte-stuffing, RST-drop and held-byte logic. It has an enable from the top FSM and returns an eoi_seen pulse.

Test Plan:
- Minimal frame FF D8, SOF0 (len 0011, height 01E0, width 02D0), SOS (len 000C), ECS 12 34, FF D9 with last -> ecs bytes 12 then 34 (last=1); frame_done=1 once; img 720×480; frame_err=0.
- ECS 12 FF 00 FF D3 56 FF D9 -> outputs 12, FF, 56 (56 with last); RST dropped; no error.
- Stream starting 00 D8 … with last on final byte -> err_code=1, no ECS output, back to S_IDLE after last; next valid frame parses cleanly (err remains sticky until start).
- jpeg_data_last asserted on an ECS byte before EOI -> err_code=2, frame_done never pulses.
- SOF0 with width 0280 -> err_code=4, ECS still emitted, frame_done pulses.
- rst_n low mid-ECS with held byte pending -> all outputs 0 immediately; after release, a new frame yields no stale byte.
